// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the seven-segment stream decoder and the display
//   encoder: segment patterns ({g,f,e,d,c,b,a}, bit 0 = a), letter codes,
//   the 16-entry message table and the message-tracker state encoding.
package seg7_pkg;

  typedef logic [3:0] sym_code_t;
  typedef logic [6:0] seg_pattern_t;

  localparam int unsigned MSG_LEN = 16;

  // Letter codes
  localparam sym_code_t CODE_U       = 4'd0;
  localparam sym_code_t CODE_A       = 4'd1;
  localparam sym_code_t CODE_B       = 4'd2;
  localparam sym_code_t CODE_C       = 4'd3;
  localparam sym_code_t CODE_DASH    = 4'd4;
  localparam sym_code_t CODE_E       = 4'd5;
  localparam sym_code_t CODE_L       = 4'd6;
  localparam sym_code_t CODE_T       = 4'd7;
  localparam sym_code_t CODE_R       = 4'd8;
  localparam sym_code_t CODE_O       = 4'd9;
  localparam sym_code_t CODE_N       = 4'd10;
  localparam sym_code_t CODE_I       = 4'd11;
  localparam sym_code_t CODE_INVALID = 4'd15;

  // Segment patterns {g,f,e,d,c,b,a}
  localparam seg_pattern_t PAT_U    = 7'b0111110;
  localparam seg_pattern_t PAT_A    = 7'b1110111;
  localparam seg_pattern_t PAT_B    = 7'b1111100;
  localparam seg_pattern_t PAT_C    = 7'b0111001;
  localparam seg_pattern_t PAT_DASH = 7'b1000000;
  localparam seg_pattern_t PAT_E    = 7'b1111001;
  localparam seg_pattern_t PAT_L    = 7'b0111000;
  localparam seg_pattern_t PAT_T    = 7'b0110001;
  localparam seg_pattern_t PAT_R    = 7'b1010000;
  localparam seg_pattern_t PAT_O    = 7'b0111111;
  localparam seg_pattern_t PAT_N    = 7'b1010100;
  localparam seg_pattern_t PAT_I    = 7'b0110000;
  localparam seg_pattern_t PAT_BLANK = 7'b0000000;

  // Message tracker states
  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_TRACK  = 1'b1
  } track_state_t;

  // Message "U A B C - E L E C T R O N I C A", indexed 0..15
  function automatic sym_code_t msg_entry(input logic [3:0] idx);
    sym_code_t code;
    case (idx)
      4'd0:    code = CODE_U;
      4'd1:    code = CODE_A;
      4'd2:    code = CODE_B;
      4'd3:    code = CODE_C;
      4'd4:    code = CODE_DASH;
      4'd5:    code = CODE_E;
      4'd6:    code = CODE_L;
      4'd7:    code = CODE_E;
      4'd8:    code = CODE_C;
      4'd9:    code = CODE_T;
      4'd10:   code = CODE_R;
      4'd11:   code = CODE_O;
      4'd12:   code = CODE_N;
      4'd13:   code = CODE_I;
      4'd14:   code = CODE_C;
      4'd15:   code = CODE_A;
      default: code = CODE_INVALID;
    endcase
    return code;
  endfunction

  // Letter code back to its segment pattern (display side); unknown codes blank
  function automatic seg_pattern_t code_to_pattern(input sym_code_t code);
    seg_pattern_t pat;
    case (code)
      CODE_U:    pat = PAT_U;
      CODE_A:    pat = PAT_A;
      CODE_B:    pat = PAT_B;
      CODE_C:    pat = PAT_C;
      CODE_DASH: pat = PAT_DASH;
      CODE_E:    pat = PAT_E;
      CODE_L:    pat = PAT_L;
      CODE_T:    pat = PAT_T;
      CODE_R:    pat = PAT_R;
      CODE_O:    pat = PAT_O;
      CODE_N:    pat = PAT_N;
      CODE_I:    pat = PAT_I;
      default:   pat = PAT_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_pattern_lut.sv
// seg7_pattern_lut
//   Combinational map from a segment pattern to its letter code.
//   Ports:
//     pattern  in  7  segment pattern {g,f,e,d,c,b,a}
//     code     out 4  letter code, 15 when the pattern is not a letter
//     invalid  out 1  high when the pattern is not in the letter table
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       invalid
);

  // Pattern lookup; anything outside the letter table is invalid
  always_comb begin
    code    = CODE_INVALID;
    invalid = 1'b1;
    case (pattern)
      PAT_U:    begin code = CODE_U;    invalid = 1'b0; end
      PAT_A:    begin code = CODE_A;    invalid = 1'b0; end
      PAT_B:    begin code = CODE_B;    invalid = 1'b0; end
      PAT_C:    begin code = CODE_C;    invalid = 1'b0; end
      PAT_DASH: begin code = CODE_DASH; invalid = 1'b0; end
      PAT_E:    begin code = CODE_E;    invalid = 1'b0; end
      PAT_L:    begin code = CODE_L;    invalid = 1'b0; end
      PAT_T:    begin code = CODE_T;    invalid = 1'b0; end
      PAT_R:    begin code = CODE_R;    invalid = 1'b0; end
      PAT_O:    begin code = CODE_O;    invalid = 1'b0; end
      PAT_N:    begin code = CODE_N;    invalid = 1'b0; end
      PAT_I:    begin code = CODE_I;    invalid = 1'b0; end
      default:  begin code = CODE_INVALID; invalid = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_stream_decoder.sv
// seg7_stream_decoder
//   Synchronizes an asynchronous seven-segment pattern, accepts a pattern once
//   it has been stable for STABLE_CYCLES synchronized cycles, decodes it to a
//   letter code and tracks the message "U A B C - E L E C T R O N I C A".
//   Ports:
//     clk        in  1  rising-edge clock
//     reset      in  1  synchronous, active-high reset
//     seg_in     in  7  asynchronous segment pattern {g,f,e,d,c,b,a}
//     sym_valid  out 1  one-cycle pulse per accepted pattern
//     sym_code   out 4  code of the last accepted pattern (15 = not a letter)
//     sym_err    out 1  pulse with sym_valid when the pattern is not a letter
//     locked     out 1  high while the tracker follows the message
//     msg_pos    out 4  message index of the last matched symbol
//     msg_done   out 1  one-cycle pulse when index 15 is matched
//     err_count  out 8  saturating count of sequence breaks
module seg7_stream_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  output logic       sym_valid,
  output logic [3:0] sym_code,
  output logic       sym_err,
  output logic       locked,
  output logic [3:0] msg_pos,
  output logic       msg_done,
  output logic [7:0] err_count
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] ACCEPT_CNT = 8'(STABLE_CYCLES - 1);

  logic [6:0]   sync1_r;
  logic [6:0]   sync2_r;
  logic [6:0]   prev_r;
  logic [6:0]   last_acc_r;
  logic [7:0]   stab_cnt_r;
  logic [7:0]   stab_cnt_next_s;
  logic         accept_s;
  logic [3:0]   lut_code_s;
  logic         lut_invalid_s;

  logic         sym_valid_r;
  logic [3:0]   sym_code_r;
  logic         sym_err_r;

  track_state_t state_r;
  track_state_t state_next_s;
  logic [3:0]   msg_pos_r;
  logic [3:0]   msg_pos_next_s;
  logic         msg_done_r;
  logic         msg_done_next_s;
  logic         locked_r;
  logic [7:0]   err_count_r;
  logic         err_inc_s;
  sym_code_t    expected_s;

  seg7_pattern_lut u_lut (
    .pattern (sync2_r),
    .code    (lut_code_s),
    .invalid (lut_invalid_s)
  );

  // Two-flop synchronizer plus previous-cycle copy for change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 7'b0000000;
      sync2_r <= 7'b0000000;
      prev_r  <= 7'b0000000;
    end else begin
      sync1_r <= seg_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Stability counter next value: clear on change, otherwise count up to STABLE_MAX
  always_comb begin
    stab_cnt_next_s = stab_cnt_r;
    if (sync2_r != prev_r) begin
      stab_cnt_next_s = 8'd0;
    end else if (stab_cnt_r < STABLE_MAX) begin
      stab_cnt_next_s = stab_cnt_r + 8'd1;
    end else begin
      stab_cnt_next_s = stab_cnt_r;
    end
  end

  // The counter passes STABLE_CYCLES-1 exactly once per run, so a held
  // pattern is accepted once; last_acc_r blocks re-acceptance after a glitch.
  assign accept_s = (stab_cnt_next_s == ACCEPT_CNT) && (sync2_r != last_acc_r);

  // Stability counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      stab_cnt_r <= 8'd0;
    end else begin
      stab_cnt_r <= stab_cnt_next_s;
    end
  end

  // Accepted-symbol registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_acc_r  <= 7'b0000000;
      sym_valid_r <= 1'b0;
      sym_code_r  <= CODE_INVALID;
      sym_err_r   <= 1'b0;
    end else begin
      sym_valid_r <= accept_s;
      sym_err_r   <= accept_s && lut_invalid_s;
      if (accept_s) begin
        last_acc_r <= sync2_r;
        sym_code_r <= lut_code_s;
      end
    end
  end

  assign expected_s = msg_entry(msg_pos_r + 4'd1);

  // Message tracker next state, position, done pulse and error increment
  always_comb begin
    state_next_s    = state_r;
    msg_pos_next_s  = msg_pos_r;
    msg_done_next_s = 1'b0;
    err_inc_s       = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_SEARCH: begin
          if (!lut_invalid_s && (lut_code_s == CODE_U)) begin
            state_next_s   = ST_TRACK;
            msg_pos_next_s = 4'd0;
          end else begin
            state_next_s   = ST_SEARCH;
          end
        end
        ST_TRACK: begin
          if (!lut_invalid_s && (lut_code_s == expected_s)) begin
            msg_pos_next_s  = msg_pos_r + 4'd1;
            msg_done_next_s = (msg_pos_r == 4'd14);
          end else begin
            err_inc_s = 1'b1;
            // A U restarts the message rather than dropping lock
            if (!lut_invalid_s && (lut_code_s == CODE_U)) begin
              state_next_s   = ST_TRACK;
              msg_pos_next_s = 4'd0;
            end else begin
              state_next_s   = ST_SEARCH;
            end
          end
        end
        default: begin
          state_next_s = ST_SEARCH;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Message tracker registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_SEARCH;
      msg_pos_r   <= 4'd0;
      msg_done_r  <= 1'b0;
      locked_r    <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      state_r    <= state_next_s;
      msg_pos_r  <= msg_pos_next_s;
      msg_done_r <= msg_done_next_s;
      locked_r   <= (state_next_s == ST_TRACK);
      if (err_inc_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'd1;
      end
    end
  end

  assign sym_valid = sym_valid_r;
  assign sym_code  = sym_code_r;
  assign sym_err   = sym_err_r;
  assign locked    = locked_r;
  assign msg_pos   = msg_pos_r;
  assign msg_done  = msg_done_r;
  assign err_count = err_count_r;

endmodule

// File: doc/seg7_stream_decoder.md
SEG7_STREAM_DECODER -- requirements
Module: seg7_stream_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive synchronized cycles a pattern must hold before acceptance (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port seg_in, input, 7, asynchronous segment pattern {g,f,e,d,c,b,a}, bit 0 = a.
REQ-005 SHALL have port sym_valid, output, 1, one-cycle pulse per accepted pattern.
REQ-006 SHALL have port sym_code, output, 4, letter code of the last accepted pattern, held between pulses.
REQ-007 SHALL have port sym_err, output, 1, one-cycle pulse coincident with sym_valid when the accepted pattern is not in the letter table.
REQ-008 SHALL have port locked, output, 1, high while the message tracker is in TRACK.
REQ-009 SHALL have port msg_pos, output, 4, message index (0..15) of the last matched symbol.
REQ-010 SHALL have port msg_done, output, 1, one-cycle pulse when index 15 is matched.
REQ-011 SHALL have port err_count, output, 8, saturating count of sequence breaks.

Function
REQ-012 SHALL pass seg_in through a 2-flop synchronizer; the filter operates only on the synchronized value.
REQ-013 SHALL clear the stability counter when the synchronized pattern differs from its previous-cycle value, and otherwise increment it, saturating at STABLE_CYCLES.
REQ-014 SHALL accept a pattern when the stability counter reaches STABLE_CYCLES-1 and the pattern differs from the last accepted pattern; a held pattern is accepted once only.
REQ-015 SHALL, for seg_in stable from cycle t onward, assert sym_valid in exactly cycle t+2+STABLE_CYCLES.
REQ-016 SHALL decode patterns: 0111110 U=0, 1110111 A=1, 1111100 B=2, 0111001 C=3, 1000000 dash=4, 1111001 E=5, 0111000 L=6, 0110001 T=7, 1010000 R=8, 0111111 O=9, 1010100 N=10, 0110000 I=11; any other pattern, including 0000000, gives code 15 with sym_err.
REQ-017 SHALL track the 16-entry message U A B C - E L E C T R O N I C A (indices 0..15) with FSM states SEARCH and TRACK.
REQ-018 SEARCH: accepted U -> TRACK, msg_pos=0; any other accepted symbol, including sym_err -> stay, no count.
REQ-019 TRACK: accepted symbol equal to entry (msg_pos+1) mod 16 -> msg_pos advances with wrap 15->0; msg_done pulses in the cycle the index-15 match is registered.
REQ-020 TRACK: mismatch or sym_err -> err_count+1 (saturates at 255, never wraps); if the symbol is U -> stay in TRACK with msg_pos=0, else -> SEARCH.
REQ-021 SHALL register sym_valid, sym_code, sym_err, msg_pos, msg_done, and locked in the same cycle, with sym_valid and msg_done never high for more than one cycle.

Reset
REQ-022 SHALL, on reset, clear sync flops to 0, stability counter to 0, last accepted pattern to 0000000, state to SEARCH, and sym_valid, sym_err, locked, msg_done, msg_pos, and err_count to 0; sym_code SHALL reset to 15.
REQ-023 SHALL, when reset is asserted mid-filter or mid-message, discard the partial acceptance; the first post-reset acceptance requires the full REQ-015 latency.

Structure
REQ-024 SHALL place the letter-code constants, the 16-entry message table, and the state encoding in shared package seg7_pkg, used also by the display encoder.
REQ-025 SHALL implement the pattern-to-code map as combinational sub-module seg7_pattern_lut; the filter and FSM stay in the top.

Verification
REQ-026 Full message sequence: STABLE_CYCLES=4, drive the 16 patterns of the message in order, each held 10 cycles -> 16 sym_valid pulses, locked from the first, msg_pos 0..15, one msg_done, err_count=0.
REQ-027 Glitch filter: hold U, pulse 1110111 for 3 cycles, then return to U -> no sym_valid for A; U is not re-accepted.
REQ-028 Sequence break: in TRACK at msg_pos=2 (B), drive T -> err_count=1, locked=0; then drive U -> locked=1, msg_pos=0.
REQ-029 Invalid pattern and saturation: drive 0000000 in TRACK -> sym_err with code 15, err_count+1; force 300 breaks -> err_count holds 255.
REQ-030 Reset mid-stream: assert reset at msg_pos=7 for 1 cycle -> all outputs at reset values next cycle; re-drive U -> sym_valid exactly 6 cycles after the change.
